// File: rtl/spi_flash_arb.sv
// Two-requester round-robin arbiter in front of a single-byte flash reader.
// Ack arrives 3 + (WAIT cycles) cycles after the request is seen in IDLE; requesters hold valid until ack.
module spi_flash_arb #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ack,
  output logic [7:0]        req0_data,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ack,
  output logic [7:0]        req1_data,
  output logic              req1_err,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [7:0]        data0_q, data0_d, data1_q, data1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic              pick;
  logic              timed_out;
  logic [7:0]        rd_byte;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_valid_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    data0_d      = data0_q;
    data1_d      = data1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    pick         = 1'b0;
    timed_out    = 1'b0;
    rd_byte      = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie, the requester that did not win last time goes first.
          pick        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          grant_d     = pick;
          mem_addr_d  = pick ? req1_addr : req0_addr;
          mem_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // mem_ready wins over a timeout landing on the same cycle.
        if (mem_ready || (cnt_q == CNT_LAST)) begin
          timed_out = ~mem_ready;
          rd_byte   = mem_ready ? mem_data : 8'h00;
          state_d   = S_DONE;
          if (grant_q) begin
            ack1_d  = 1'b1;
            data1_d = rd_byte;
            err1_d  = timed_out;
          end else begin
            ack0_d  = 1'b1;
            data0_d = rd_byte;
            err0_d  = timed_out;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      data0_q      <= 8'h00;
      data1_q      <= 8'h00;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  assign req0_ack  = ack0_q;
  assign req1_ack  = ack1_q;
  assign req0_data = data0_q;
  assign req1_data = data1_q;
  assign req0_err  = err0_q;
  assign req1_err  = err1_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = (state_q != S_IDLE);
  assign grant     = grant_q;

endmodule

// File: tb/tb_spi_flash_arb.sv
// Directed bench for spi_flash_arb with TIMEOUT=8: a per-cycle vector table
// for the basic read, then hand sequences for arbitration, timeout and reset.
module tb_spi_flash_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_addr, req1_addr;
  logic        req0_ack, req1_ack;
  logic [7:0]  req0_data, req1_data;
  logic        req0_err, req1_err;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        busy, grant;

  int n_chk  = 0;
  int n_fail = 0;

  spi_flash_arb #(.ADDR_W(24), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ack(req0_ack),
    .req0_data(req0_data), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ack(req1_ack),
    .req1_data(req1_data), .req1_err(req1_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, v0, v1;
    logic [23:0] a0, a1;
    logic rdy;
    logic [7:0] md;
    logic ack0, ack1;
    logic [7:0] d0, d1;
    logic e0, e1, mv;
    logic [23:0] maddr;
    logic bsy, gnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_step();
    @(posedge clk); #1;
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle acks", 32'({req0_ack, req1_ack}), 32'd0);
  endtask

  // Called in an IDLE cycle with the request(s) already driven; returns in the DONE cycle.
  task automatic serve(input logic g, input logic [23:0] addr, input int ready_at,
                       input logic [7:0] rdat, input logic drop,
                       input logic exp_err, input logic [7:0] exp_dat);
    int w;
    int exp_w;
    logic got;
    @(posedge clk); #1;
    chk("issue mem_valid", 32'(mem_valid), 32'd1);
    chk("issue mem_addr", 32'(mem_addr), 32'(addr));
    chk("issue grant", 32'(grant), 32'(g));
    chk("issue busy", 32'(busy), 32'd1);
    if (drop) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("wait mem_valid", 32'(mem_valid), 32'd0);
    w = 0;
    got = 1'b0;
    while (!got && w < 20) begin
      w++;
      if (w == ready_at) begin
        mem_ready = 1'b1;
        mem_data  = rdat;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_data  = 8'h00;
      got = req0_ack | req1_ack;
    end
    exp_w = (ready_at != 0) ? ready_at : 8;
    chk("wait cycles", 32'(w), 32'(exp_w));
    chk("ack granted", 32'(g ? req1_ack : req0_ack), 32'd1);
    chk("ack other", 32'(g ? req0_ack : req1_ack), 32'd0);
    chk("ack data", 32'(g ? req1_data : req0_data), 32'(exp_dat));
    chk("ack err", 32'(g ? req1_err : req0_err), 32'(exp_err));
    chk("done mem_addr", 32'(mem_addr), 32'(addr));
    chk("done grant", 32'(grant), 32'(g));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rst v0 v1 a0        a1 rdy md     ack0 ack1 d0     d1 e0 e1 mv maddr     bsy gnt
    vecs[0] = '{1, 0, 0, 24'h0,    0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 24'h0,    0, 0};
    vecs[1] = '{0, 1, 0, 24'h0000AA, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 24'h0000AA, 1, 0};
    vecs[2] = '{0, 1, 0, 24'h0000AA, 0, 1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 0, 24'h0000AA, 1, 0};
    vecs[3] = '{0, 1, 0, 24'h0000AA, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 24'h0000AA, 1, 0};
    vecs[4] = '{0, 1, 0, 24'h0000AA, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 24'h0000AA, 1, 0};
    vecs[5] = '{0, 1, 0, 24'h0000AA, 0, 1, 8'hAA, 1, 0, 8'hAA, 0, 0, 0, 0, 24'h0000AA, 1, 0};
    vecs[6] = '{0, 0, 0, 24'h0000AA, 0, 0, 8'h00, 0, 0, 8'hAA, 0, 0, 0, 0, 24'h0000AA, 0, 0};
    vecs[7] = '{0, 0, 0, 24'h0000AA, 0, 1, 8'hFF, 0, 0, 8'hAA, 0, 0, 0, 0, 24'h0000AA, 0, 0};

    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_addr = 0; req1_addr = 0;
    mem_ready = 0; mem_data = 0;

    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst; req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
      req0_addr = vecs[i].a0; req1_addr = vecs[i].a1;
      mem_ready = vecs[i].rdy; mem_data = vecs[i].md;
      @(posedge clk); #1;
      chk($sformatf("row%0d ack0", i), 32'(req0_ack), 32'(vecs[i].ack0));
      chk($sformatf("row%0d ack1", i), 32'(req1_ack), 32'(vecs[i].ack1));
      chk($sformatf("row%0d data0", i), 32'(req0_data), 32'(vecs[i].d0));
      chk($sformatf("row%0d data1", i), 32'(req1_data), 32'(vecs[i].d1));
      chk($sformatf("row%0d err0", i), 32'(req0_err), 32'(vecs[i].e0));
      chk($sformatf("row%0d err1", i), 32'(req1_err), 32'(vecs[i].e1));
      chk($sformatf("row%0d mem_valid", i), 32'(mem_valid), 32'(vecs[i].mv));
      chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("row%0d grant", i), 32'(grant), 32'(vecs[i].gnt));
    end
    mem_ready = 0; mem_data = 0;

    // Tie after reset: req0 first, req1 next, then req0 wins the following tie.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    req0_addr = 24'h10; req1_addr = 24'h20; req0_valid = 1; req1_valid = 1;
    serve(1'b0, 24'h10, 1, 8'h01, 1'b0, 1'b0, 8'h01);
    req0_valid = 0;
    idle_step();
    serve(1'b1, 24'h20, 2, 8'h02, 1'b0, 1'b0, 8'h02);
    chk("req0_data held", 32'(req0_data), 32'h01);
    req0_valid = 1;
    idle_step();
    serve(1'b0, 24'h10, 1, 8'h03, 1'b0, 1'b0, 8'h03);
    req0_valid = 0; req1_valid = 0;
    idle_step();

    // Timeout on req1, with the requester dropping valid mid-transaction.
    req1_addr = 24'h000333; req1_valid = 1;
    serve(1'b1, 24'h000333, 0, 8'h00, 1'b1, 1'b1, 8'h00);
    idle_step();
    chk("timeout err1 held", 32'(req1_err), 32'd1);
    chk("req0_data held2", 32'(req0_data), 32'h03);

    // mem_ready on the last allowed WAIT cycle counts as success.
    req0_addr = 24'h005C5C; req0_valid = 1;
    serve(1'b0, 24'h005C5C, 8, 8'h5C, 1'b0, 1'b0, 8'h5C);
    req0_valid = 0;
    idle_step();

    // Reset during WAIT, then a stray mem_ready, then a normal read.
    req0_addr = 24'h000777; req0_valid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1; req0_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst mem_valid", 32'(mem_valid), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst acks", 32'({req0_ack, req1_ack}), 32'd0);
    chk("rst data0", 32'(req0_data), 32'd0);
    chk("rst data1", 32'(req1_data), 32'd0);
    chk("rst errs", 32'({req0_err, req1_err}), 32'd0);
    mem_ready = 1; mem_data = 8'h99;
    @(posedge clk); #1;
    mem_ready = 0; mem_data = 0;
    chk("stray ready busy", 32'(busy), 32'd0);
    chk("stray ready acks", 32'({req0_ack, req1_ack}), 32'd0);
    chk("stray ready data0", 32'(req0_data), 32'd0);
    req0_addr = 24'h000042; req0_valid = 1;
    serve(1'b0, 24'h000042, 2, 8'h42, 1'b0, 1'b0, 8'h42);
    req0_valid = 0;
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
